uart_tx_stream: RTL
===================

Name: uart_tx_stream

Overview:
- Standalone 8N1 UART transmitter carrying the FPGA→ESP32 direction: status, acknowledgements and read-back data.
- Upstream logic hands it bytes over a valid/ready stream.
- Bytes are buffered in a small synchronous FIFO and serialised back-to-back at BAUD on txd.

Parameters:
- CLK_FREQ, 125_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate. CYCLES_PER_BIT = CLK_FREQ/BAUD (integer divide, 1085 at defaults).
- STOP_BITS, 1: number of stop bits, 1 or 2.
- FIFO_DEPTH, 16: byte entries; must be a power of 2.
- PTR_SIZE, 4: log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- s_data  in  8  byte to send
- s_valid  in  1  s_data is valid
- s_ready  out  1  FIFO can accept a byte; equals !full
- txd  out  1  serial line out; idles high
- busy  out  1  high when a frame is in progress or the FIFO is non-empty
- tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit
- fifo_level  out  PTR_SIZE+1  current number of bytes held in the FIFO

Behaviour:
- Reset values (asynchronous): txd=1, busy=0, tx_done=0, s_ready=1, fifo_level=0, state=IDLE, counters=0, FIFO emptied. Assertion mid-frame aborts the frame and forces txd high immediately. The frame is not resumed after reset.
- Accept rule: a byte is accepted on any rising edge where s_valid && s_ready.
  - s_ready is registered (!full). It stays low for the whole cycle the FIFO is full, even if a pop happens in that same cycle.
  - s_valid while s_ready=0 is ignored; the producer holds s_data.
- FIFO:
  - Show-ahead: head byte is visible whenever non-empty.
  - Simultaneous push and pop when non-empty and not full: fifo_level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level ranges 0..FIFO_DEPTH.
- State machine: IDLE, START, DATA, STOP. There is a 16-bit cycle counter, a 3-bit bit index and a 1-bit stop index.
  - IDLE: txd=1.
    - If FIFO non-empty: latch head into tx_byte, pop, txd<=0, counter<=0, go to START.
  - START: hold txd=0 for CYCLES_PER_BIT cycles.
    - Then bit index<=0, go to DATA.
  - DATA: txd=tx_byte[bit index], LSB first, each bit lasting CYCLES_PER_BIT cycles.
    - After bit 7, go to STOP.
  - STOP: txd=1 for STOP_BITS*CYCLES_PER_BIT cycles.
    - On the last cycle, pulse tx_done.
    - If FIFO non-empty: pop, latch, txd<=0 and go to START (no idle gap between frames).
    - Otherwise go to IDLE.
- Latency: a byte accepted at edge k into an empty, idle block drives txd low after edge k+2.
- Frame length: exactly (1+8+STOP_BITS)*CYCLES_PER_BIT cycles, which is 10850 at the defaults.
- busy = (state!=IDLE) || !empty. It is registered and drops in the cycle after the final tx_done.
- Width rules:
  - CYCLES_PER_BIT must satisfy 2 ≤ CYCLES_PER_BIT ≤ 65535; elaboration fails otherwise.
  - The counter compares against CYCLES_PER_BIT-1 and never free-runs past it.
- Boundaries:
  - FIFO full: further s_valid is back-pressured. No byte is dropped or overwritten.
  - A byte pushed during the last STOP cycle into an empty FIFO is not seen that cycle. The block goes IDLE, then starts the next cycle (one idle bit-cycle gap of a single clock).

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3);
  - the CYCLES_PER_BIT calculation;
  - the default CLK_FREQ and BAUD constants.
- One sub-module, byte_fifo: a parameterised synchronous show-ahead FIFO with wr_en, rd_en, wr_data, rd_data, empty, full and level.

Test Plan:
- Reset, then push 0x55 → txd low 2 cycles after accept; line shows 0,1,0,1,0,1,0,1,0,1; each bit 1085±0 cycles; tx_done pulses once at cycle 10850 of the frame; busy then falls.
- Push 0xA5, 0x3C, 0xFF back-to-back → three contiguous frames with no high gap between stop and next start; LSB-first bits match; 3 tx_done pulses spaced 10850 cycles apart.
- Hold s_valid with 20 incrementing bytes (0x00..0x13) while line busy → s_ready drops when fifo_level=16; all 20 bytes are eventually sent in order with no duplicates or loss.
- Assert rst at mid-DATA of byte 0x81 with 5 bytes queued → txd=1 immediately; fifo_level=0; no further frames or tx_done after release.
- STOP_BITS=2, BAUD=9600 → 0x00 frame lasts 11*13020 cycles; stop high for 26040 cycles.
- Push a byte exactly on the last STOP cycle of a previous frame with the FIFO empty → the byte is transmitted correctly after a single idle cycle; fifo_level returns to 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// default clocking constants and the bit-period calculation.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ = 125_000_000;
    localparam int DEFAULT_BAUD     = 115_200;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic int cycles_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_stream_byte_fifo.sv
// Synchronous show-ahead byte FIFO; the head entry is visible on rd_data
// whenever the FIFO is non-empty.
module byte_fifo #(
    parameter int DEPTH    = 16,
    parameter int PTR_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [7:0]          wr_data,
    input  logic                rd_en,
    output logic [7:0]          rd_data,
    output logic                empty,
    output logic                full,
    output logic [PTR_SIZE:0]   level
);

    localparam logic [PTR_SIZE:0] DEPTH_L = (PTR_SIZE + 1)'(DEPTH);

    logic [7:0]          mem_q [DEPTH];
    logic [PTR_SIZE-1:0] wr_ptr_q;
    logic [PTR_SIZE-1:0] rd_ptr_q;
    logic [PTR_SIZE:0]   count_q;
    logic                push_s;
    logic                pop_s;

    assign empty   = (count_q == (PTR_SIZE + 1)'(0));
    assign full    = (count_q == DEPTH_L);
    assign push_s  = wr_en && !full;
    assign pop_s   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_SIZE'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_SIZE'(1);
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + (PTR_SIZE + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_SIZE + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_s) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_stream.sv
// 8N1 (or 8N2) UART transmitter fed by a valid/ready byte stream through a
// small FIFO; frames are sent back-to-back while bytes are queued.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_SIZE   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                txd,
    output logic                busy,
    output logic                tx_done,
    output logic [PTR_SIZE:0]   fifo_level
);

    localparam int                CPB       = cycles_per_bit(CLK_FREQ, BAUD);
    localparam logic [15:0]       CPB_LAST  = 16'(CPB - 1);
    localparam logic [0:0]        STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [PTR_SIZE:0] DEPTH_L   = (PTR_SIZE + 1)'(FIFO_DEPTH);

    if (CPB < 2 || CPB > 65535) begin : g_bad_cpb
        $fatal(1, "CYCLES_PER_BIT must lie within 2..65535");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $fatal(1, "STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH != (1 << PTR_SIZE)) begin : g_bad_depth
        $fatal(1, "FIFO_DEPTH must equal 2**PTR_SIZE");
    end

    logic [1:0]        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              txd_q, busy_q, tx_done_q, s_ready_q;
    logic              fifo_empty_s, fifo_full_s, push_s, pop_s;
    logic              bit_end_s, frame_end_s, line_s;
    logic [7:0]        head_s;
    logic [PTR_SIZE:0] level_s, level_nxt_s;

    byte_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .PTR_SIZE (PTR_SIZE)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data (s_data),
        .rd_en   (pop_s),
        .rd_data (head_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s),
        .level   (level_s)
    );

    assign push_s      = s_valid && s_ready_q && !fifo_full_s;
    assign bit_end_s   = (cnt_q == CPB_LAST);
    assign frame_end_s = (state_q == ST_STOP) && bit_end_s && (stop_idx_q == STOP_LAST);
    assign pop_s       = !fifo_empty_s && ((state_q == ST_IDLE) || frame_end_s);

    // Occupancy after this edge; s_ready is registered from it so it is
    // never high while the FIFO is full.
    always_comb begin
        level_nxt_s = level_s;
        if (push_s && !pop_s) begin
            level_nxt_s = level_s + (PTR_SIZE + 1)'(1);
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_s - (PTR_SIZE + 1)'(1);
        end else begin
            level_nxt_s = level_s;
        end
    end

    // Frame sequencer: bit timing, bit index and stop-bit index.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        if (pop_s) begin
            tx_byte_d = head_s;
        end else begin
            tx_byte_d = tx_byte_q;
        end
        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (pop_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    cnt_d     = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (!bit_end_s) begin
                    cnt_d = cnt_q + 16'd1;
                end else if (bit_idx_q == 3'd7) begin
                    cnt_d      = 16'd0;
                    stop_idx_d = 1'b0;
                    state_d    = ST_STOP;
                end else begin
                    cnt_d     = 16'd0;
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (!bit_end_s) begin
                    cnt_d = cnt_q + 16'd1;
                end else if (frame_end_s) begin
                    cnt_d   = 16'd0;
                    state_d = pop_s ? ST_START : ST_IDLE;
                end else begin
                    cnt_d      = 16'd0;
                    stop_idx_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level implied by the current state; registered once more on output.
    always_comb begin
        case (state_q)
            ST_START: line_s = 1'b0;
            ST_DATA:  line_s = tx_byte_q[bit_idx_q];
            default:  line_s = 1'b1;
        endcase
    end

    // State and output registers; reset forces the line idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            tx_byte_q  <= 8'd0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
            s_ready_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_byte_q  <= tx_byte_d;
            txd_q      <= line_s;
            busy_q     <= (state_q != ST_IDLE) || !fifo_empty_s;
            tx_done_q  <= frame_end_s;
            s_ready_q  <= (level_nxt_s != DEPTH_L);
        end
    end

    assign s_ready    = s_ready_q;
    assign txd        = txd_q;
    assign busy       = busy_q;
    assign tx_done    = tx_done_q;
    assign fifo_level = level_s;

endmodule
